// File: rtl/mem_arb_pkg.sv
// Shared command codes, FSM state type and ID-width helper for the memory request arbiter.
package mem_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWbeat1
  } arb_state_e;

  // Client ID width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/req_tag_fifo.sv
// Synchronous FIFO of client IDs for outstanding reads; supports push and pop in the same cycle.
module req_tag_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO may still accept a push when it is popped in the same cycle.
    do_push  = push && ((count_q != CntW'(Depth)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing the DDR2 command and write-data FIFOs among memory clients,
// with read tags so returned read beats are steered to the issuing client.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     c_req_valid,
  input  logic [3*NUM_REQ-1:0]   c_req_cmd,
  input  logic [31*NUM_REQ-1:0]  c_req_addr,
  output logic [NUM_REQ-1:0]     c_req_ready,
  input  logic [128*NUM_REQ-1:0] c_wdf_din,
  input  logic [16*NUM_REQ-1:0]  c_wdf_mask_din,
  output logic [NUM_REQ-1:0]     c_wdf_ready,
  output logic [NUM_REQ-1:0]     c_rdf_valid,
  input  logic                   af_full,
  input  logic                   wdf_full,
  input  logic                   rdf_valid,
  output logic                   af_wr_en,
  output logic [2:0]             af_cmd_din,
  output logic [30:0]            af_addr_din,
  output logic                   wdf_wr_en,
  output logic [127:0]           wdf_din,
  output logic [15:0]            wdf_mask_din,
  output logic                   rdf_rd_en,
  output logic                   protocol_err
);

  localparam int unsigned IdW  = id_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             beat_q, beat_d;
  logic             err_q, err_d;

  logic [2:0]       cmd_arr  [NUM_REQ];
  logic [30:0]      addr_arr [NUM_REQ];
  logic [127:0]     data_arr [NUM_REQ];
  logic [15:0]      mask_arr [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IdW-1:0]     pick_id;
  logic [IdW-1:0]     rr_next;
  logic               tag_full, tag_push, tag_pop, is_write;
  logic [IdW-1:0]     tag_head;
  logic [CntW-1:0]    tag_count;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_arr[i]  = c_req_cmd[3*i +: 3];
      addr_arr[i] = c_req_addr[31*i +: 31];
      data_arr[i] = c_wdf_din[128*i +: 128];
      mask_arr[i] = c_wdf_mask_din[16*i +: 16];
    end
  end

  // Anything that is not a write consumes a tag, so it is masked once the tag FIFO is full.
  assign tag_full = (tag_count == CntW'(TAG_DEPTH));

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = c_req_valid[i] && !((cmd_arr[i] != CMD_WRITE) && tag_full);
    end
  end

  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_id    = IdW'(idx);
      end
    end
    rr_next = (pick_id == IdW'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cmd_d        = cmd_q;
    af_wr_en     = 1'b0;
    af_cmd_din   = '0;
    af_addr_din  = '0;
    wdf_wr_en    = 1'b0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    c_req_ready  = '0;
    c_wdf_ready  = '0;
    tag_push     = 1'b0;
    is_write     = (cmd_q == CMD_WRITE);

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d  = pick_id;
          cmd_d    = cmd_arr[pick_id];
          rr_ptr_d = rr_next;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        af_cmd_din  = cmd_q;
        af_addr_din = addr_arr[grant_q];
        if (is_write) begin
          wdf_din      = data_arr[grant_q];
          wdf_mask_din = mask_arr[grant_q];
          // Command and beat 0 go together or not at all.
          if (!af_full && !wdf_full) begin
            af_wr_en             = 1'b1;
            wdf_wr_en            = 1'b1;
            c_req_ready[grant_q] = 1'b1;
            c_wdf_ready[grant_q] = 1'b1;
            state_d              = StWbeat1;
          end
        end else if (!af_full) begin
          af_wr_en             = 1'b1;
          c_req_ready[grant_q] = 1'b1;
          tag_push             = 1'b1;
          state_d              = StIdle;
        end
      end
      StWbeat1: begin
        wdf_din      = data_arr[grant_q];
        wdf_mask_din = mask_arr[grant_q];
        if (!wdf_full) begin
          wdf_wr_en            = 1'b1;
          c_wdf_ready[grant_q] = 1'b1;
          state_d              = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Each read returns two beats; the tag retires after the second.
  always_comb begin
    rdf_rd_en   = rdf_valid && (tag_count != '0);
    beat_d      = rdf_rd_en ? ~beat_q : beat_q;
    tag_pop     = rdf_rd_en && beat_q;
    err_d       = err_q || (rdf_valid && (tag_count == '0));
    c_rdf_valid = '0;
    if (rdf_rd_en) begin
      c_rdf_valid[tag_head] = 1'b1;
    end
  end

  assign protocol_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cmd_q    <= '0;
      beat_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cmd_q    <= cmd_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  req_tag_fifo #(
    .Depth (TAG_DEPTH),
    .Width (IdW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (grant_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (tag_count)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: client queues drive requests, a transaction-level
// round-robin model predicts FIFO writes and read steering, and a monitor checks them.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     c_req_valid;
  logic [3*N-1:0]   c_req_cmd;
  logic [31*N-1:0]  c_req_addr;
  logic [N-1:0]     c_req_ready;
  logic [128*N-1:0] c_wdf_din;
  logic [16*N-1:0]  c_wdf_mask_din;
  logic [N-1:0]     c_wdf_ready;
  logic [N-1:0]     c_rdf_valid;
  logic             af_full, wdf_full, rdf_valid;
  logic             af_wr_en, wdf_wr_en, rdf_rd_en, protocol_err;
  logic [2:0]       af_cmd_din;
  logic [30:0]      af_addr_din;
  logic [127:0]     wdf_din;
  logic [15:0]      wdf_mask_din;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_REQ   (N),
    .TAG_DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .c_req_valid    (c_req_valid),
    .c_req_cmd      (c_req_cmd),
    .c_req_addr     (c_req_addr),
    .c_req_ready    (c_req_ready),
    .c_wdf_din      (c_wdf_din),
    .c_wdf_mask_din (c_wdf_mask_din),
    .c_wdf_ready    (c_wdf_ready),
    .c_rdf_valid    (c_rdf_valid),
    .af_full        (af_full),
    .wdf_full       (wdf_full),
    .rdf_valid      (rdf_valid),
    .af_wr_en       (af_wr_en),
    .af_cmd_din     (af_cmd_din),
    .af_addr_din    (af_addr_din),
    .wdf_wr_en      (wdf_wr_en),
    .wdf_din        (wdf_din),
    .wdf_mask_din   (wdf_mask_din),
    .rdf_rd_en      (rdf_rd_en),
    .protocol_err   (protocol_err)
  );

  typedef struct {
    logic [2:0]   cmd;
    logic [30:0]  addr;
    logic [127:0] d0, d1;
    logic [15:0]  m0, m1;
  } txn_t;
  typedef struct { int client; logic [2:0] cmd; logic [30:0] addr; } exp_af_t;
  typedef struct { int client; logic [127:0] data; logic [15:0] mask; } exp_wdf_t;
  typedef struct { int client; bit last; } exp_rdf_t;

  txn_t     cq    [N][$];
  txn_t     stage [N][$];
  exp_af_t  exp_af  [$];
  exp_wdf_t exp_wdf [$];
  exp_rdf_t exp_rdf [$];

  int checks = 0;
  int errors = 0;
  int m_rr = 0;
  int reads_pushed = 0, reads_done = 0;
  int beats_avail = 0;
  int af_cnt = 0, wdf_pulses = 0, mcyc = 0, wdf_cyc_prev = 0, wdf_cyc_last = 0;
  bit resp_en = 0, rnd_full = 0, af_force = 0, wdf_force = 0, force_rdf = 0, err_exp = 0;
  bit [N-1:0]   b1_pend = '0;
  logic [127:0] b1_d [N];
  logic [15:0]  b1_m [N];
  logic         s_af, s_wdf, s_rd, s_err;
  logic [2:0]   s_cmd;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (cq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    txn_t h;
    for (int i = 0; i < N; i++) begin
      c_req_valid[i] = (cq[i].size() != 0);
      h = '{cmd: 3'b0, addr: 31'b0, d0: 128'b0, d1: 128'b0, m0: 16'b0, m1: 16'b0};
      if (cq[i].size() != 0) h = cq[i][0];
      c_req_cmd[3*i +: 3]       = h.cmd;
      c_req_addr[31*i +: 31]    = h.addr;
      c_wdf_din[128*i +: 128]   = b1_pend[i] ? b1_d[i] : h.d0;
      c_wdf_mask_din[16*i +: 16] = b1_pend[i] ? b1_m[i] : h.m0;
    end
    af_full   = af_force || (rnd_full && ($urandom_range(3) == 0));
    wdf_full  = wdf_force || (rnd_full && ($urandom_range(3) == 0));
    rdf_valid = force_rdf || (resp_en && (beats_avail > 0) && ($urandom_range(3) != 0));
  endtask

  // One clock: the client/memory side reacts to the handshakes seen this cycle.
  task automatic step();
    txn_t h;
    @(negedge clk);
    s_af  = af_wr_en;
    s_wdf = wdf_wr_en;
    s_rd  = rdf_rd_en;
    s_cmd = af_cmd_din;
    s_err = protocol_err;
    for (int i = 0; i < N; i++) begin
      if (c_wdf_ready[i]) begin
        if (b1_pend[i]) b1_pend[i] = 1'b0;
        else if (cq[i].size() != 0) begin
          h = cq[i][0];
          b1_pend[i] = 1'b1;
          b1_d[i] = h.d1;
          b1_m[i] = h.m1;
        end
      end
      if (c_req_ready[i] && (cq[i].size() != 0)) void'(cq[i].pop_front());
    end
    if (af_wr_en && (af_cmd_din != CMD_WRITE)) beats_avail += 2;
    if (rdf_rd_en && (beats_avail > 0)) beats_avail--;
    @(posedge clk);
    #1;
    drive();
  endtask

  // Staged transactions are granted round-robin among clients with work, starting at m_rr.
  task automatic commit_round();
    int left, c;
    txn_t t;
    left = 0;
    for (int i = 0; i < N; i++) left += stage[i].size();
    while (left > 0) begin
      c = -1;
      for (int k = 0; k < N; k++) begin
        if ((c < 0) && (stage[(m_rr + k) % N].size() != 0)) c = (m_rr + k) % N;
      end
      t = stage[c].pop_front();
      cq[c].push_back(t);
      m_rr = (c + 1) % N;
      exp_af.push_back('{client: c, cmd: t.cmd, addr: t.addr});
      if (t.cmd == CMD_WRITE) begin
        exp_wdf.push_back('{client: c, data: t.d0, mask: t.m0});
        exp_wdf.push_back('{client: c, data: t.d1, mask: t.m1});
      end else begin
        exp_rdf.push_back('{client: c, last: 1'b0});
        exp_rdf.push_back('{client: c, last: 1'b1});
        reads_pushed++;
      end
      left--;
    end
    drive();
  endtask

  function automatic txn_t mk(input logic [2:0] cmd, input logic [30:0] addr);
    txn_t t;
    t.cmd  = cmd;
    t.addr = addr;
    t.d0   = {$urandom, $urandom, $urandom, $urandom};
    t.d1   = {$urandom, $urandom, $urandom, $urandom};
    t.m0   = 16'($urandom);
    t.m1   = 16'($urandom);
    return t;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (any_pending() && (n < budget)) begin
      step();
      n++;
    end
    check({name, "_timeout"}, any_pending(), 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    resp_en = 1'b1;
    while (((exp_af.size() + exp_wdf.size() + exp_rdf.size()) != 0) && (n < budget)) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, exp_af.size() + exp_wdf.size() + exp_rdf.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_af_t  ea;
    exp_wdf_t ew;
    exp_rdf_t er;
    mcyc++;
    if (!rst) begin
      if (af_wr_en) begin
        af_cnt++;
        check("af_while_full", af_full, 1'b0);
        if (exp_af.size() == 0) check("af_unexpected", af_wr_en, 1'b0);
        else begin
          ea = exp_af.pop_front();
          check("af_client", c_req_ready, onehot(ea.client));
          check("af_cmd", af_cmd_din, ea.cmd);
          check("af_addr", af_addr_din, ea.addr);
          if (ea.cmd == CMD_WRITE) check("af_beat0_same_cycle", wdf_wr_en, 1'b1);
        end
      end else begin
        check("req_ready_idle", c_req_ready, '0);
      end
      if (wdf_wr_en) begin
        wdf_pulses++;
        wdf_cyc_prev = wdf_cyc_last;
        wdf_cyc_last = mcyc;
        check("wdf_while_full", wdf_full, 1'b0);
        if (exp_wdf.size() == 0) check("wdf_unexpected", wdf_wr_en, 1'b0);
        else begin
          ew = exp_wdf.pop_front();
          check("wdf_client", c_wdf_ready, onehot(ew.client));
          check("wdf_data", wdf_din, ew.data);
          check("wdf_mask", wdf_mask_din, ew.mask);
        end
      end else begin
        check("wdf_ready_idle", c_wdf_ready, '0);
      end
      if (rdf_rd_en) begin
        check("rd_en_without_valid", rdf_valid, 1'b1);
        if (exp_rdf.size() == 0) check("rdf_unexpected", rdf_rd_en, 1'b0);
        else begin
          er = exp_rdf.pop_front();
          check("rdf_steer", c_rdf_valid, onehot(er.client));
          if (er.last) reads_done++;
        end
      end else begin
        check("rdf_steer_idle", c_rdf_valid, '0);
      end
      check("protocol_err", protocol_err, err_exp);
    end
  end

  initial begin
    int a0, p0, n, w;
    rst = 1'b1;
    c_req_valid = '0; c_req_cmd = '0; c_req_addr = '0;
    c_wdf_din = '0; c_wdf_mask_din = '0;
    af_full = 1'b0; wdf_full = 1'b0; rdf_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_af_wr_en", af_wr_en, 1'b0);
    check("rst_wdf_wr_en", wdf_wr_en, 1'b0);
    check("rst_ready", {c_req_ready, c_wdf_ready, c_rdf_valid}, '0);
    check("rst_rd_en_err", {rdf_rd_en, protocol_err}, 2'b00);
    check("rst_af_data", {af_cmd_din, af_addr_din}, '0);
    rst = 1'b0;
    drive();
    step();

    // Reads from every client with no returns: grants rotate and stop at eight outstanding.
    resp_en = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < 3; j++)
      stage[i].push_back(mk(CMD_READ, 31'(16 * i + j)));
    a0 = af_cnt;
    commit_round();
    n = 0;
    while (((af_cnt - a0) < 8) && (n < 60)) begin step(); n++; end
    check("tagfull_eight_grants", af_cnt - a0, 8);
    repeat (20) step();
    check("tagfull_no_more_grants", af_cnt - a0, 8);
    wait_drain("tagfull", 400);
    check("tagfull_all_issued", af_cnt - a0, 12);

    // Single read from client 2.
    a0 = af_cnt;
    stage[2].push_back(mk(CMD_READ, 31'h100));
    commit_round();
    wait_drain("single_read", 100);
    check("single_read_af_count", af_cnt - a0, 1);

    // Write from client 0 stalled by a full address FIFO.
    af_force = 1'b1;
    stage[0].push_back(mk(CMD_WRITE, 31'h2000));
    commit_round();
    for (int i = 0; i < 5; i++) begin
      step();
      check("afstall_no_writes", {s_af, s_wdf}, 2'b00);
    end
    p0 = wdf_pulses;
    af_force = 1'b0;
    drive();
    wait_drain("afstall", 100);
    check("afstall_beat_pulses", wdf_pulses - p0, 2);
    check("afstall_beat1_next_cycle", wdf_cyc_last - wdf_cyc_prev, 1);

    // Reads from 3 then 1 outstanding together: returns steer 3,3,1,1.
    resp_en = 1'b0;
    stage[3].push_back(mk(CMD_READ, 31'h33));
    commit_round();
    wait_idle("interleave_a", 50);
    stage[1].push_back(mk(CMD_READ, 31'h11));
    commit_round();
    wait_idle("interleave_b", 50);
    wait_drain("interleave", 100);

    // Write data FIFO full during beat 1 holds the beat and blocks the next command.
    w = m_rr;
    stage[w].push_back(mk(CMD_WRITE, 31'h4444));
    stage[(w + 1) % N].push_back(mk(CMD_READ, 31'h5555));
    commit_round();
    n = 0;
    s_af = 1'b0;
    while (!(s_af && (s_cmd == CMD_WRITE)) && (n < 20)) begin step(); n++; end
    check("wbeat_write_issued", s_af && (s_cmd == CMD_WRITE), 1'b1);
    wdf_force = 1'b1;
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      check("wbeat_stall_no_writes", {s_af, s_wdf}, 2'b00);
    end
    wdf_force = 1'b0;
    drive();
    wait_drain("wbeat", 100);

    // Randomized rounds with random FIFO back-pressure and read returns.
    rnd_full = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int nreads, tot;
      logic [2:0] cmd;
      nreads = 0;
      tot = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1) == 1) begin
          for (int j = 0; j <= int'($urandom_range(1)); j++) begin
            n = $urandom_range(9);
            cmd = (n < 5) ? CMD_WRITE : (n < 9) ? CMD_READ : 3'($urandom_range(7, 2));
            stage[i].push_back(mk(cmd, 31'($urandom)));
            if (cmd != CMD_WRITE) nreads++;
            tot++;
          end
        end
      end
      if (tot == 0) begin
        stage[$urandom_range(N - 1)].push_back(mk(CMD_WRITE, 31'($urandom)));
      end
      resp_en = 1'b1;
      n = 0;
      while (((reads_pushed - reads_done + nreads) > 8) && (n < 300)) begin step(); n++; end
      check("rand_tag_room_timeout", (reads_pushed - reads_done + nreads) > 8, 1'b0);
      resp_en = 1'($urandom_range(1));
      commit_round();
      wait_idle("rand_round", 300);
    end
    rnd_full = 1'b0;
    wait_drain("rand", 2000);

    // Read data with nothing outstanding: not popped, sticky error until reset.
    resp_en = 1'b0;
    force_rdf = 1'b1;
    drive();
    step();
    check("proterr_first_no_pop", s_rd, 1'b0);
    err_exp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("proterr_no_pop", s_rd, 1'b0);
      check("proterr_set", s_err, 1'b1);
    end
    force_rdf = 1'b0;
    drive();
    repeat (2) step();
    check("proterr_sticky", s_err, 1'b1);
    rst = 1'b1;
    #1;
    err_exp = 1'b0;
    check("proterr_cleared_by_rst", protocol_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_outputs", {af_wr_en, wdf_wr_en, rdf_rd_en, protocol_err}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that shares the DDR2 address/command FIFO and write-data FIFO among NUM_REQ memory clients (caches, cache bypass, frame filler, line engine, pixel feeder). It issues each client's command atomically with its write beats and tags every read with the issuing client's ID so returned read-FIFO beats are steered back to the right client. It sits between the clients and the clock-crossing FIFOs on the CPU clock domain.

## Interface
- NUM_REQ, 4: number of clients (2..8)
- TAG_DEPTH, 8: max outstanding reads (power of 2)
- clk  in  1  CPU clock; all FIFO write/read ports are on this clock
- rst  in  1  asynchronous, active-high reset
- c_req_valid  in  NUM_REQ  client i holds a command request
- c_req_cmd  in  3*NUM_REQ  command per client: 000 write, 001 read
- c_req_addr  in  31*NUM_REQ  DDR2 address per client
- c_req_ready  out  NUM_REQ  one-cycle pulse: command accepted into af
- c_wdf_din  in  128*NUM_REQ  current write beat per client
- c_wdf_mask_din  in  16*NUM_REQ  current write mask per client
- c_wdf_ready  out  NUM_REQ  one-cycle pulse per write beat consumed
- c_rdf_valid  out  NUM_REQ  client i owns the rdf beat this cycle
- af_full, wdf_full, rdf_valid  in  1 each  FIFO status
- af_wr_en, af_cmd_din[2:0], af_addr_din[30:0]  out  address FIFO write port
- wdf_wr_en, wdf_din[127:0], wdf_mask_din[15:0]  out  write-data FIFO write port
- rdf_rd_en  out  1  read-FIFO pop
- protocol_err  out  1  sticky: rdf_valid with no outstanding tag

## Operation
- States: IDLE, ISSUE, WBEAT1.
- IDLE: eligible = c_req_valid masked by (cmd==read && tag_count==TAG_DEPTH). Pick first eligible at or after rr_ptr (wrapping); register grant ID, cmd, go ISSUE. rr_ptr <= winner+1 mod NUM_REQ. No eligible: stay.
- ISSUE, read: when !af_full, af_wr_en=1, cmd/addr from winner, c_req_ready[winner]=1, push winner ID into tag FIFO, go IDLE. af_full: hold, outputs stable.
- ISSUE, write: when !af_full && !wdf_full, af_wr_en=1 and wdf_wr_en=1 (beat 0) in the same cycle, c_req_ready and c_wdf_ready pulse, go WBEAT1. Either full: hold, no partial issue.
- WBEAT1: when !wdf_full, wdf_wr_en=1 (beat 1), c_wdf_ready pulse, go IDLE.
- Client must keep req/addr/cmd stable until c_req_ready, and present beat 1 on the cycle after c_wdf_ready for beat 0.
- Read return: rdf_rd_en = rdf_valid && tag_count!=0; c_rdf_valid[tag_head]=rdf_rd_en. 1-bit beat counter; pop tag after second beat. rdf_valid with tag_count==0: rdf_rd_en=0, protocol_err set until reset.
- Tag push and pop in same cycle: count unchanged. Read eligibility uses the registered count (no credit for same-cycle pop).
- Unknown cmd codes issued as read (no data beats).

## Timing
- Reset: state IDLE, rr_ptr 0, tag FIFO empty, beat counter 0, all outputs 0.
- Request visible at cycle t in IDLE -> af_wr_en earliest at t+1; write beat 1 earliest at t+2.
- Back-to-back: one command per 2 cycles (read), 3 cycles (write).
- All FIFO-side outputs combinational from registered state plus full flags; no combinational path from c_req_valid to af_wr_en.
- Read steering zero-latency: c_rdf_valid in the cycle rdf_rd_en asserts; client samples rdf_dout that cycle.
- Reset mid-write: arbiter returns IDLE immediately; system reset also flushes the FIFOs.

## Structure
- Package mem_arb_pkg: CMD_WRITE=3'b000, CMD_READ=3'b001, state enum, ID width function clog2(NUM_REQ).
- Sub-module req_tag_fifo: TAG_DEPTH x ID-width synchronous FIFO with count output, simultaneous push/pop.

## Test plan
- Single read from client 2, addr 31'h100: af_wr_en one cycle with cmd 001; two rdf_valid beats -> c_rdf_valid=4'b0100 twice, tag count 1->0.
- Write from client 0 with af_full held 5 cycles: no af/wdf writes during stall; then af+beat0 same cycle, beat1 next; exactly 2 c_wdf_ready pulses.
- All 4 clients request reads continuously: grants 0,1,2,3,0...; after 8 grants with no returns, no further af_wr_en until a read pair returns.
- Interleaved returns: reads from clients 3 then 1 outstanding -> first two beats to 3, next two to 1.
- wdf_full asserted during WBEAT1: beat1 withheld, no new command issued, resumes when clear.
- rdf_valid with no outstanding reads: rdf_rd_en stays 0, protocol_err=1 until rst.
